// File: rtl/stream_perm_buf_if.sv
// rtl/stream_perm_buf_if.sv - framed P-lane complex sample stream bundle
//
// Purpose: carries one ctrl-pulse framed stream of P complex lanes.
// Ports (modport master drives, slave receives):
//   ctrl : frame-start pulse, one cycle before the first beat
//   x    : P real parts, lane l at [l*W +: W], lane 0 in the LSBs
//   y    : P imaginary parts, packed like x
interface stream_perm_buf_if #(
   parameter int W = 8,
   parameter int P = 4
);
   logic             ctrl;
   logic [P*W-1:0]   x;
   logic [P*W-1:0]   y;

   modport master (output ctrl, x, y);
   modport slave  (input  ctrl, x, y);
endinterface

// File: rtl/stream_perm_buf.sv
// rtl/stream_perm_buf.sv - double-buffered streaming permutation buffer
//
// Purpose: captures frames of N complex samples arriving P lanes per beat
// and replays each frame in bit-reversed (MODE 0), identity (MODE 1) or
// stride-transposed (MODE 2) order, ping-ponging between two banks.
// Ports:
//   clk       : clock, rising edge
//   rst_in    : synchronous active-high reset
//   src       : input stream (ctrl pulse, then N/P beats)
//   dst       : output stream, registered; zeros while not draining
//   abort_out : one-cycle pulse when a partial input frame is dropped
module stream_perm_buf #(
   parameter int W    = 8,
   parameter int P    = 4,
   parameter int N    = 16,
   parameter int MODE = 0
) (
   input  logic              clk,
   input  logic              rst_in,
   stream_perm_buf_if.slave  src,
   stream_perm_buf_if.master dst,
   output logic              abort_out
);
   localparam int B  = N / P;
   localparam int LG = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (B > 1) ? $clog2(B) : 1;
   localparam logic [CW-1:0] LAST = CW'(B - 1);

   typedef enum logic {W_IDLE, W_FILL}  w_state_t;
   typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

   w_state_t       w_state, w_state_nxt;
   r_state_t       r_state, r_state_nxt;
   logic [CW-1:0]  wcnt, wcnt_nxt;
   logic [CW-1:0]  rcnt, rcnt_nxt;
   logic           wbank, wbank_nxt;
   logic           rbank, rbank_nxt;
   logic           wr_en;
   logic           rd_start;
   logic           abort;
   logic [P*W-1:0] rd_x, rd_y;

   logic [W-1:0]   mem_x [0:1][0:N-1];
   logic [W-1:0]   mem_y [0:1][0:N-1];

   // Source word for output beat/lane; pure bit manipulation, no table.
   function automatic logic [LG-1:0] perm_idx(input logic [CW-1:0] beat, input int lane);
      logic [LG-1:0] k;
      logic [LG-1:0] r;
      k = LG'(int'(beat) * P + lane);
      case (MODE)
         0:       r = {<<{k}};
         // k mod P is the lane and k div P is the beat, so the
         // transpose source is lane*B + beat.
         2:       r = LG'(lane * B + int'(beat));
         default: r = k;
      endcase
      return r;
   endfunction

   // Write FSM: a ctrl pulse opens a frame; a ctrl pulse before the last
   // beat drops the partial frame and restarts it in the same bank.
   always_comb begin
      w_state_nxt = w_state;
      wcnt_nxt    = wcnt;
      wbank_nxt   = wbank;
      wr_en       = 1'b0;
      rd_start    = 1'b0;
      abort       = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (src.ctrl) begin
               w_state_nxt = W_FILL;
               wcnt_nxt    = '0;
            end
         end
         W_FILL: begin
            if (src.ctrl && wcnt != LAST) begin
               abort    = 1'b1;
               wcnt_nxt = '0;
            end else begin
               wr_en = 1'b1;
               if (wcnt == LAST) begin
                  wbank_nxt   = ~wbank;
                  rd_start    = 1'b1;
                  wcnt_nxt    = '0;
                  // ctrl on the last beat chains the next frame gaplessly
                  w_state_nxt = src.ctrl ? W_FILL : W_IDLE;
               end else begin
                  wcnt_nxt = wcnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Read FSM: rd_start hands over the bank that was just completed.
   always_comb begin
      r_state_nxt = r_state;
      rcnt_nxt    = rcnt;
      rbank_nxt   = rbank;
      if (rd_start) begin
         r_state_nxt = R_DRAIN;
         rcnt_nxt    = '0;
         rbank_nxt   = wbank;
      end else if (r_state == R_DRAIN) begin
         if (rcnt == LAST) begin
            r_state_nxt = R_IDLE;
            rcnt_nxt    = '0;
         end else begin
            rcnt_nxt = rcnt + 1'b1;
         end
      end
   end

   always_comb begin
      rd_x = '0;
      rd_y = '0;
      for (int l = 0; l < P; l++) begin
         rd_x[l*W +: W] = mem_x[rbank][perm_idx(rcnt, l)];
         rd_y[l*W +: W] = mem_y[rbank][perm_idx(rcnt, l)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         w_state   <= W_IDLE;
         r_state   <= R_IDLE;
         wcnt      <= '0;
         rcnt      <= '0;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         dst.ctrl  <= 1'b0;
         dst.x     <= '0;
         dst.y     <= '0;
         abort_out <= 1'b0;
      end else begin
         w_state   <= w_state_nxt;
         r_state   <= r_state_nxt;
         wcnt      <= wcnt_nxt;
         rcnt      <= rcnt_nxt;
         wbank     <= wbank_nxt;
         rbank     <= rbank_nxt;
         dst.ctrl  <= rd_start;
         dst.x     <= (r_state == R_DRAIN) ? rd_x : '0;
         dst.y     <= (r_state == R_DRAIN) ? rd_y : '0;
         abort_out <= abort;
      end
   end

   // Storage carries no reset; contents only matter once a frame completes.
   always_ff @(posedge clk) begin
      if (wr_en && !rst_in) begin
         for (int l = 0; l < P; l++) begin
            mem_x[wbank][LG'(int'(wcnt) * P + l)] <= src.x[l*W +: W];
            mem_y[wbank][LG'(int'(wcnt) * P + l)] <= src.y[l*W +: W];
         end
      end
   end
endmodule

// File: tb/tb_stream_perm_buf.sv
// tb/tb_stream_perm_buf.sv - self-checking bench for stream_perm_buf
module tb_stream_perm_buf;
   localparam int MAXC = 512;
   localparam logic [31:0] Y_OFS = 32'h40404040;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stream_perm_buf_if #(.W(8),  .P(4)) src_a ();
   stream_perm_buf_if #(.W(8),  .P(4)) dst_r ();
   stream_perm_buf_if #(.W(8),  .P(4)) dst_s ();
   stream_perm_buf_if #(.W(12), .P(8)) src_b ();
   stream_perm_buf_if #(.W(12), .P(8)) dst_b ();
   logic abort_r, abort_s, abort_b;

   stream_perm_buf #(.W(8), .P(4), .N(16), .MODE(0)) u_rev (
      .clk(clk), .rst_in(rst), .src(src_a), .dst(dst_r), .abort_out(abort_r));
   stream_perm_buf #(.W(8), .P(4), .N(16), .MODE(2)) u_str (
      .clk(clk), .rst_in(rst), .src(src_a), .dst(dst_s), .abort_out(abort_s));
   stream_perm_buf #(.W(12), .P(8), .N(64), .MODE(1)) u_id (
      .clk(clk), .rst_in(rst), .src(src_b), .dst(dst_b), .abort_out(abort_b));

   // Output log indexed by the edge number at which each value was registered.
   logic        lg_ctrl_r [MAXC];
   logic        lg_abort_r[MAXC];
   logic [31:0] lg_x_r    [MAXC];
   logic [31:0] lg_y_r    [MAXC];
   logic        lg_ctrl_s [MAXC];
   logic [31:0] lg_x_s    [MAXC];
   logic [31:0] lg_y_s    [MAXC];
   logic        lg_ctrl_b [MAXC];
   logic [95:0] lg_x_b    [MAXC];
   logic [95:0] lg_y_b    [MAXC];

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         lg_ctrl_r[cyc]  = dst_r.ctrl;
         lg_abort_r[cyc] = abort_r;
         lg_x_r[cyc]     = dst_r.x;
         lg_y_r[cyc]     = dst_r.y;
         lg_ctrl_s[cyc]  = dst_s.ctrl;
         lg_x_s[cyc]     = dst_s.x;
         lg_y_s[cyc]     = dst_s.y;
         lg_ctrl_b[cyc]  = dst_b.ctrl;
         lg_x_b[cyc]     = dst_b.x;
         lg_y_b[cyc]     = dst_b.y;
      end
   end

   typedef struct {
      logic [31:0] x_in;
      logic [31:0] exp_rev;
      logic [31:0] exp_str;
   } vec_t;
   vec_t vec [4];

   logic [95:0] bx [16];
   logic [95:0] by [16];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_a(input logic c, input logic [31:0] x, input logic [31:0] y);
      src_a.ctrl = c;
      src_a.x    = x;
      src_a.y    = y;
      step();
   endtask

   task automatic idle_all();
      src_a.ctrl = 1'b0; src_a.x = '0; src_a.y = '0;
      src_b.ctrl = 1'b0; src_b.x = '0; src_b.y = '0;
   endtask

   initial begin
      int e0;
      int cnt;
      logic [31:0] ofs;

      // beat inputs and hand-computed bit-reversed / stride-transposed beats
      vec[0] = '{32'h03020100, 32'h0C04_0800, 32'h0C08_0400};
      vec[1] = '{32'h07060504, 32'h0E06_0A02, 32'h0D09_0501};
      vec[2] = '{32'h0B0A0908, 32'h0D05_0901, 32'h0E0A_0602};
      vec[3] = '{32'h0F0E0D0C, 32'h0F07_0B03, 32'h0F0B_0703};

      // reset held 20 cycles with random inputs
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         src_a.ctrl = 1'($urandom);
         src_a.x    = $urandom;
         src_a.y    = $urandom;
         src_b.ctrl = 1'($urandom);
         src_b.x    = {$urandom, $urandom, $urandom};
         src_b.y    = {$urandom, $urandom, $urandom};
         step();
         check("reset_outputs",
               {dst_r.ctrl, abort_r, dst_r.x, dst_r.y, dst_s.ctrl, abort_s,
                dst_b.ctrl, abort_b, dst_b.x[31:0]}, '0);
      end
      rst = 1'b0;
      idle_all();
      repeat (3) step();

      // single frame, MODE 0 and MODE 2 side by side
      beat_a(1'b0, 32'h55555555, 32'h0);   // beat while idle: ignored
      beat_a(1'b1, 32'hDEADBEEF, 32'h0);
      e0 = cyc;
      for (int t = 0; t < 4; t++) beat_a(1'b0, vec[t].x_in, vec[t].x_in | Y_OFS);
      idle_all();
      repeat (8) step();
      check("rev_ctrl_before", lg_ctrl_r[e0+3], 1'b0);
      check("rev_ctrl_pulse",  lg_ctrl_r[e0+4], 1'b1);
      check("rev_ctrl_after",  lg_ctrl_r[e0+5], 1'b0);
      check("str_ctrl_pulse",  lg_ctrl_s[e0+4], 1'b1);
      check("rev_idle_zero",   lg_x_r[e0+4], 32'h0);
      for (int t = 0; t < 4; t++) begin
         check($sformatf("rev_x_beat%0d", t), lg_x_r[e0+5+t], vec[t].exp_rev);
         check($sformatf("rev_y_beat%0d", t), lg_y_r[e0+5+t], vec[t].exp_rev | Y_OFS);
         check($sformatf("str_x_beat%0d", t), lg_x_s[e0+5+t], vec[t].exp_str);
         check($sformatf("str_y_beat%0d", t), lg_y_s[e0+5+t], vec[t].exp_str | Y_OFS);
      end
      check("rev_drain_done", lg_x_r[e0+9], 32'h0);

      // three back-to-back frames, values offset by 16 per frame
      beat_a(1'b1, 32'h0, 32'h0);
      e0 = cyc;
      for (int f = 0; f < 3; f++) begin
         ofs = 32'h10101010 * f;
         for (int t = 0; t < 4; t++)
            beat_a(t == 3 && f < 2, vec[t].x_in + ofs, (vec[t].x_in + ofs) | Y_OFS);
      end
      idle_all();
      repeat (8) step();
      for (int c = 3; c < 18; c++)
         check($sformatf("b2b_ctrl_e%0d", c), lg_ctrl_r[e0+c],
               (c == 4 || c == 8 || c == 12) ? 1'b1 : 1'b0);
      for (int j = 0; j < 12; j++) begin
         ofs = 32'h10101010 * (j / 4);
         check($sformatf("b2b_x_beat%0d", j), lg_x_r[e0+5+j], vec[j%4].exp_rev + ofs);
         check($sformatf("b2b_str_beat%0d", j), lg_x_s[e0+5+j], vec[j%4].exp_str + ofs);
      end
      check("b2b_gap_after", lg_x_r[e0+17], 32'h0);

      // mid-frame restart: ctrl again after two beats
      beat_a(1'b1, 32'h0, 32'h0);
      e0 = cyc;
      beat_a(1'b0, 32'hA3A2A1A0, 32'hB3B2B1B0);
      beat_a(1'b0, 32'hA7A6A5A4, 32'hB7B6B5B4);
      beat_a(1'b1, 32'hABAAA9A8, 32'hBBBAB9B8);
      for (int t = 0; t < 4; t++)
         beat_a(1'b0, vec[t].x_in + 32'h20202020, (vec[t].x_in + 32'h20202020) | Y_OFS);
      idle_all();
      repeat (8) step();
      check("abort_pulse", lg_abort_r[e0+3], 1'b1);
      cnt = 0;
      for (int c = 0; c < 15; c++) cnt += int'(lg_abort_r[e0+c]);
      check("abort_count", cnt, 1);
      cnt = 0;
      for (int c = 0; c < 15; c++) cnt += int'(lg_ctrl_r[e0+c]);
      check("restart_ctrl_count", cnt, 1);
      check("restart_ctrl_pulse", lg_ctrl_r[e0+7], 1'b1);
      cnt = 0;
      for (int c = 0; c < 15; c++) cnt += int'(lg_x_r[e0+c] != 32'h0);
      check("restart_nonzero_beats", cnt, 4);
      for (int t = 0; t < 4; t++)
         check($sformatf("restart_x_beat%0d", t), lg_x_r[e0+8+t], vec[t].exp_rev + 32'h20202020);

      // reset mid-drain, with ctrl asserted during the reset cycle
      beat_a(1'b1, 32'h0, 32'h0);
      e0 = cyc;
      for (int t = 0; t < 4; t++) beat_a(1'b0, vec[t].x_in, vec[t].x_in | Y_OFS);
      idle_all();
      step();
      rst = 1'b1;
      src_a.ctrl = 1'b1;
      step();
      rst = 1'b0;
      for (int t = 0; t < 4; t++) beat_a(1'b0, vec[t].x_in, vec[t].x_in);
      idle_all();
      repeat (6) step();
      check("rst_drain_beat0", lg_x_r[e0+5], vec[0].exp_rev);
      check("rst_drain_zero1", lg_x_r[e0+6], 32'h0);
      check("rst_drain_zero2", lg_y_r[e0+7], 32'h0);
      cnt = 0;
      for (int c = 6; c < 16; c++) cnt += int'(lg_ctrl_r[e0+c]) + int'(lg_x_r[e0+c] != 32'h0);
      check("rst_dominates_ctrl", cnt, 0);

      // MODE 1, N=64, P=8, W=12: two back-to-back random frames
      for (int j = 0; j < 16; j++) begin
         bx[j] = {$urandom, $urandom, $urandom};
         by[j] = {$urandom, $urandom, $urandom};
      end
      src_b.ctrl = 1'b1;
      step();
      e0 = cyc;
      for (int j = 0; j < 16; j++) begin
         src_b.ctrl = (j == 7);
         src_b.x    = bx[j];
         src_b.y    = by[j];
         step();
      end
      idle_all();
      repeat (12) step();
      check("id_ctrl_f0", lg_ctrl_b[e0+8], 1'b1);
      check("id_ctrl_f1", lg_ctrl_b[e0+16], 1'b1);
      check("id_ctrl_gap", lg_ctrl_b[e0+12], 1'b0);
      for (int j = 0; j < 16; j++) begin
         check($sformatf("id_x_beat%0d", j), lg_x_b[e0+9+j], bx[j]);
         check($sformatf("id_y_beat%0d", j), lg_y_b[e0+9+j], by[j]);
      end
      check("id_drain_done", lg_x_b[e0+25], 96'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
